// File: rtl/mem_access_ctrl.sv
// Byte/half/word load-store initiator for a word-addressed memory; sub-word stores use
// read-modify-write. Optional macro MEMCTRL_SUBWORD_EN enables byte and half accesses.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e state_q;
  logic   req_err;

`ifdef MEMCTRL_SUBWORD_EN
  logic        we_q;
  logic        signed_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic        unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_W+2];

  always_comb begin
    req_err = 1'b0;
    unique case (req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = (req_addr[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
  end

  // Big-endian lanes: offset 0 is the most significant byte.
  function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] size,
                                               input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'h00;
    unique case (off)
      2'd0: b = w[31:24];
      2'd1: b = w[23:16];
      2'd2: b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    if (size == 2'b00) begin
      r = {{24{sgn & b[7]}}, b};
    end else if (size == 2'b01) begin
      r = {{16{sgn & h[15]}}, h};
    end else begin
      r = w;
    end
    return r;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] d,
                                             input logic [1:0] size, input logic [1:0] off);
    logic [31:0] r;
    r = old;
    if (size == 2'b00) begin
      unique case (off)
        2'd0: r[31:24] = d[7:0];
        2'd1: r[23:16] = d[7:0];
        2'd2: r[15:8]  = d[7:0];
        default: r[7:0] = d[7:0];
      endcase
    end else if (off[1]) begin
      r[15:0] = d[15:0];
    end else begin
      r[31:16] = d[15:0];
    end
    return r;
  endfunction
`else
  logic unused_in;

  assign unused_in = ^{req_addr[31:ADDR_W+2], req_signed};

  always_comb begin
    req_err = (req_size != 2'b10) || (req_addr[1:0] != 2'b00);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= 32'h0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
`ifdef MEMCTRL_SUBWORD_EN
      we_q      <= 1'b0;
      signed_q  <= 1'b0;
      size_q    <= 2'b00;
      off_q     <= 2'b00;
      wdata_q   <= 32'h0;
`endif
    end else begin
      done   <= 1'b0;
      err    <= 1'b0;
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req) begin
            busy     <= 1'b1;
            mem_addr <= 32'(req_addr[ADDR_W+1:2]);
`ifdef MEMCTRL_SUBWORD_EN
            we_q     <= req_we;
            signed_q <= req_signed;
            size_q   <= req_size;
            off_q    <= req_addr[1:0];
            wdata_q  <= req_wdata;
`endif
            if (req_err) begin
              state_q <= StDone;
              done    <= 1'b1;
              err     <= 1'b1;
            end else if (req_we && req_size == 2'b10) begin
              state_q   <= StWrite;
              mem_we    <= 1'b1;
              mem_wdata <= req_wdata;
            end else begin
              state_q <= StRead;
              mem_re  <= 1'b1;
            end
          end
        end
        StRead: begin
`ifdef MEMCTRL_SUBWORD_EN
          if (we_q) begin
            mem_wdata <= lane_merge(mem_rdata, wdata_q, size_q, off_q);
            state_q   <= StWrite;
            mem_we    <= 1'b1;
          end else begin
            rdata   <= lane_extract(mem_rdata, size_q, off_q, signed_q);
            state_q <= StDone;
            done    <= 1'b1;
          end
`else
          // Only word loads reach READ in this build.
          rdata   <= mem_rdata;
          state_q <= StDone;
          done    <= 1'b1;
`endif
        end
        StWrite: begin
          state_q <= StDone;
          done    <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural word memory; covers whichever
// MEMCTRL_SUBWORD_EN build is compiled.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        busy, done, err, mem_we, mem_re;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:1023];

  int n_cmp = 0;
  int n_err = 0;
  int lat, n_re, n_we, re_k, we_k;
  logic        err_seen;
  logic [31:0] we_addr;

  mem_access_ctrl #(.ADDR_W(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .rdata      (rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_re ? mem[mem_addr[9:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request and profile the cycles up to done (bounded to 6 edges).
  task automatic op(input logic we, input logic [1:0] sz, input logic sgn,
                    input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    req = 1'b1; req_we = we; req_size = sz; req_signed = sgn; req_addr = addr;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req = 1'b0;
    lat = 0; n_re = 0; n_we = 0; re_k = 0; we_k = 0; err_seen = 1'b0; we_addr = 32'h0;
    for (int k = 1; k <= 6; k++) begin
      if (mem_re) begin
        n_re++;
        if (re_k == 0) re_k = k;
      end
      if (mem_we) begin
        n_we++;
        we_k = k;
        we_addr = mem_addr;
      end
      if (done) begin
        lat = k;
        err_seen = err;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (lat != 0) @(posedge clk);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_err"}, err, 0);
    chk({pfx, "_rdata"}, rdata, 0);
    chk({pfx, "_mem_re"}, mem_re, 0);
    chk({pfx, "_mem_we"}, mem_we, 0);
    chk({pfx, "_mem_addr"}, mem_addr, 0);
    chk({pfx, "_mem_wdata"}, mem_wdata, 0);
  endtask

  task automatic chk_err_op(input string tag);
    chk({tag, "_lat"}, lat, 1);
    chk({tag, "_err"}, err_seen, 1);
    chk({tag, "_access"}, n_re + n_we, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);

    // Word store then word load at 0x10.
    op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("wst_lat", lat, 2);
    chk("wst_we_cycles", n_we, 1);
    chk("wst_re_cycles", n_re, 0);
    chk("wst_addr", we_addr, 4);
    chk("wst_err", err_seen, 0);
    chk("wst_mem", mem[4], 32'hDEADBEEF);
    op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("wld_lat", lat, 2);
    chk("wld_re_cycles", n_re, 1);
    chk("wld_rdata", rdata, 32'hDEADBEEF);

    // Error requests; rdata must be held.
    op(1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
    chk_err_op("err_half");
    op(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
    chk_err_op("err_word");
    op(1'b1, 2'b11, 1'b0, 32'h10, 32'h0);
    chk_err_op("err_size");
    chk("err_rdata_held", rdata, 32'hDEADBEEF);

`ifdef MEMCTRL_SUBWORD_EN
    op(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055);
    chk("bst_lat", lat, 3);
    chk("bst_re_k", re_k, 1);
    chk("bst_we_k", we_k, 2);
    chk("bst_re_cycles", n_re, 1);
    chk("bst_we_cycles", n_we, 1);
    chk("bst_mem", mem[4], 32'hDE55BEEF);
    op(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    chk("lb_s13", rdata, 32'hFFFFFFEF);
    op(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    chk("lb_u13", rdata, 32'h000000EF);
    op(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    chk("lh_s10", rdata, 32'hFFFFDE55);
    op(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    chk("lh_u12", rdata, 32'h0000BEEF);
    op(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
    chk("lb_s10", rdata, 32'hFFFFFFDE);
    op(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000A5C3);
    chk("hst_mem", mem[4], 32'hDE55A5C3);
    op(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055);
    op(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000BEEF);
    chk("hst_restore", mem[4], 32'hDE55BEEF);
`else
    op(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    chk_err_op("nosub_lb");
    op(1'b1, 2'b01, 1'b0, 32'h10, 32'h0);
    chk_err_op("nosub_sh");
    op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("nosub_wld_lat", lat, 2);
    chk("nosub_wld_rdata", rdata, 32'hDEADBEEF);
`endif

    // Reset while the write is pending: mem_we must drop before the edge.
    @(negedge clk);
    req = 1'b1; req_we = 1'b1; req_signed = 1'b0; req_addr = 32'h10;
`ifdef MEMCTRL_SUBWORD_EN
    req_size = 2'b00; req_wdata = 32'h000000AA;
`else
    req_size = 2'b10; req_wdata = 32'h0BADF00D;
`endif
    @(posedge clk);
    #1;
    req = 1'b0;
`ifdef MEMCTRL_SUBWORD_EN
    @(posedge clk);
    #1;
`endif
    chk("rst_we_before", mem_we, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_we_async", mem_we, 0);
    @(posedge clk);
    #1;
`ifdef MEMCTRL_SUBWORD_EN
    chk("rst_mem_kept", mem[4], 32'hDE55BEEF);
`else
    chk("rst_mem_kept", mem[4], 32'hDEADBEEF);
`endif
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);

    // Upper byte-address bits are ignored: 0x1010 aliases word 4.
    op(1'b1, 2'b10, 1'b0, 32'h1010, 32'h12345678);
    chk("wrap_addr", we_addr, 4);
    op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("wrap_rdata", rdata, 32'h12345678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory access initiator for the multicycle MIPS datapath. Accepts byte, halfword and word load/store requests at byte addresses, and drives the word-addressed `memory` block (combinational read while `re`, write on `posedge clk` while `we`). Sub-word stores are done by read-modify-write. Load data is returned aligned and sign- or zero-extended.

## Interface
- `ADDR_W`, default 10: word-address bits driven to memory; byte-address bits above `ADDR_W+1` are ignored, so addresses wrap.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 1: request strobe; sampled only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `req_signed` in 1: sign-extend load result; ignored for word loads and for stores.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; byte in [7:0], half in [15:0].
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`. Flags misaligned, reserved-size or disabled-size requests.
- `rdata` out 32: load result; held until the next load completes.
- `mem_addr` out 32: `{zeros, latched_addr[ADDR_W+1:2]}`.
- `mem_wdata` out 32: word to write.
- `mem_we` out 1: memory write enable.
- `mem_re` out 1: memory read enable.
- `mem_rdata` in 32: memory read data; valid only while `mem_re` is high.

## Operation
- Byte order is big-endian:
  - byte offset 0 → bits [31:24], offset 3 → bits [7:0];
  - half offset 0 → [31:16], offset 2 → [15:0].
- The request is latched at acceptance (IDLE & `req` at a rising edge). Inputs are don't-care afterwards. `req` is ignored while `busy`.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE transitions on `req`:
  - error condition → DONE with `err` = 1. No memory access.
  - load → READ.
  - word store → WRITE.
  - sub-word store → READ.
- Error conditions:
  - half with `addr[0]` = 1;
  - word with `addr[1:0]` ≠ 0;
  - size 11.
- READ: `mem_re` = 1.
  - Load: at the edge, the selected lane is extracted and extended into `rdata`, then → DONE.
  - Store: at the edge, `mem_rdata` is latched as the old word, then → WRITE.
- WRITE: `mem_we` = 1.
  - `mem_wdata` = `req_wdata` (word), or the old word with the addressed lane replaced.
  - → DONE.
- DONE: `done` = 1 for exactly one cycle, then → IDLE. `err` is 0 except on error completions.
- `mem_re` and `mem_we` are never high together. Both are 0 in IDLE and DONE.
- `mem_addr` and `mem_wdata` are registered or decoded from latched state. They are stable throughout READ and WRITE.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `err` 0, `rdata` 0, `mem_re` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0.
- Latency from the accepting edge to `done` high:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- `req` may be held high continuously. The next request is accepted in the IDLE cycle after DONE, so there is one idle cycle between operations.
- Reset mid-operation: state → IDLE immediately and `mem_we` drops asynchronously, so no write occurs at the following edge. `rdata` is cleared.
- Sub-word store: the memory content is unchanged until the WRITE edge, and lanes outside the addressed byte or half are preserved bit-exact.

## Configuration
- `MEMCTRL_SUBWORD_EN` defined: byte and half accesses are supported as above.
- `MEMCTRL_SUBWORD_EN` undefined: only size 10 is legal.
  - Sizes 00 and 01 complete as errors (IDLE → DONE, `err` = 1).
  - READ-before-WRITE, the lane-merge and the extend logic are not built.
  - `req_signed` is ignored.

## Test plan
- Word store, then word load, at `addr` 0x10 with data 0xDEADBEEF:
  - store: `mem_we` high for one cycle with `mem_addr` 4, and `done` 2 cycles after acceptance;
  - load: `rdata` = 0xDEADBEEF.
- With word 4 = 0xDEADBEEF, byte store 0x55 to `addr` 0x11 → word 4 = 0xDE55BEEF. `mem_re` is high one cycle before `mem_we`, and `done` is 3 cycles after acceptance.
- Loads from word 4 = 0xDE55BEEF:
  - signed byte at 0x13 → `rdata` 0xFFFFFFEF;
  - unsigned byte at 0x13 → 0x000000EF;
  - signed half at 0x10 → 0xFFFFDE55.
- Error requests:
  - half at 0x11 → `done` and `err` 1 cycle after acceptance, no `mem_re`/`mem_we`;
  - word at 0x12 → same;
  - size 11 → same.
- Reset asserted during the WRITE state of a byte store → `mem_we` low immediately, memory word unchanged, all outputs at reset values.
- Build with `MEMCTRL_SUBWORD_EN` undefined, then issue a byte load at 0x10 → `err` = 1 after 1 cycle, no memory access. A word load at 0x10 still succeeds.
